scroll_sequencer: RTL and testbench

- Controls the rotating 4-digit message display: generates the 4-bit message pointer that the anode driver and LED decoder consume, replacing the free-running fixed-period pointer counter.
- Supports three modes: auto-rotate with selectable speed, manual stepping from push-buttons, and a load mode that rewrites the 16x4 message memory through a valid/ready port.
- Sits between board I/O (switch, buttons, host/UART writer) and the anode-mux/message-memory datapath, in the clk_out (5 MHz MMCM) domain.

---
 rtl/scroll_sequencer.sv | 135 +++++++++++++
 tb/tb_scroll_sequencer.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/scroll_sequencer.sv
// scroll_sequencer: message pointer sequencer for the rotating 4-digit display
// (auto-rotate, debounced manual stepping, and message-memory load port).
module scroll_sequencer #(
    parameter int PERIOD     = 8388608,
    parameter int TICK_W     = 23,
    parameter int DEB_CYCLES = 65535,
    parameter int DEB_W      = 16
) (
    input  logic       clk_out,
    input  logic       reset_use,
    input  logic       mode_sw,
    input  logic       btn_next,
    input  logic       btn_prev,
    input  logic [1:0] speed_sel,
    input  logic       wr_valid,
    input  logic [3:0] wr_addr,
    input  logic [3:0] wr_data,
    output logic       wr_ready,
    output logic [3:0] pointer,
    output logic       step,
    output logic       mem_we,
    output logic [3:0] mem_waddr,
    output logic [3:0] mem_wdata,
    output logic [1:0] state
);
    typedef enum logic [1:0] {AUTO = 2'd0, MANUAL = 2'd1, LOAD = 2'd2} state_t;
    localparam int TW1 = TICK_W + 1;
    // PERIOD may be 2**TICK_W, so the shifted period is formed one bit wider
    localparam logic [TICK_W:0] PER = TW1'(PERIOD);
    localparam logic [TICK_W-1:0] TICK_RST = TICK_W'(PERIOD - 1);
    localparam logic [DEB_W-1:0] DEB_MAX = DEB_W'(DEB_CYCLES - 1);
    state_t st;
    logic mode_s1, mode_s2;
    logic [1:0] btn_s1, btn_s2, deb, press;
    logic [1:0][DEB_W-1:0] deb_cnt;
    logic [TICK_W-1:0] tick, reload;
    logic [TICK_W:0] p_full;
    always_comb begin
        p_full = PER >> speed_sel;
        reload = (p_full == '0) ? '0 : TICK_W'(p_full - 1'b1);
    end
    assign state = st;
    // Index 0 is next, index 1 is prev; press is a one-cycle rise of the debounced level
    always_ff @(posedge clk_out or posedge reset_use) begin
        if (reset_use) begin
            mode_s1 <= 1'b1;
            mode_s2 <= 1'b1;
            btn_s1  <= '0;
            btn_s2  <= '0;
            deb     <= '0;
            press   <= '0;
            deb_cnt <= '0;
        end else begin
            mode_s1 <= mode_sw;
            mode_s2 <= mode_s1;
            btn_s1  <= {btn_prev, btn_next};
            btn_s2  <= btn_s1;
            press   <= '0;
            for (int i = 0; i < 2; i++) begin
                if (btn_s2[i] == deb[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] == DEB_MAX) begin
                    deb_cnt[i] <= '0;
                    deb[i]     <= ~deb[i];
                    press[i]   <= ~deb[i];
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + 1'b1;
                end
            end
        end
    end
    always_ff @(posedge clk_out or posedge reset_use) begin
        if (reset_use) begin
            st        <= AUTO;
            tick      <= TICK_RST;
            pointer   <= '0;
            step      <= 1'b0;
            wr_ready  <= 1'b0;
            mem_we    <= 1'b0;
            mem_waddr <= '0;
            mem_wdata <= '0;
        end else begin
            step   <= 1'b0;
            mem_we <= 1'b0;
            case (st)
                AUTO: begin
                    if (wr_valid) begin
                        st   <= LOAD;
                        tick <= reload;
                    end else if (!mode_s2) begin
                        st   <= MANUAL;
                        tick <= reload;
                    end else if (tick == '0) begin
                        tick    <= reload;
                        pointer <= pointer + 1'b1;
                        step    <= 1'b1;
                    end else begin
                        tick <= tick - 1'b1;
                    end
                end
                MANUAL: begin
                    tick <= reload;
                    if (wr_valid) begin
                        st <= LOAD;
                    end else if (mode_s2) begin
                        st <= AUTO;
                    end else if (press[0] ^ press[1]) begin
                        pointer <= press[0] ? pointer + 1'b1 : pointer - 1'b1;
                        step    <= 1'b1;
                    end
                end
                LOAD: begin
                    tick <= reload;
                    if (wr_ready && !wr_valid) begin
                        st       <= mode_s2 ? AUTO : MANUAL;
                        pointer  <= '0;
                        step     <= |pointer;
                        wr_ready <= 1'b0;
                    end else begin
                        wr_ready <= 1'b1;
                        if (wr_valid && wr_ready) begin
                            mem_we    <= 1'b1;
                            mem_waddr <= wr_addr;
                            mem_wdata <= wr_data;
                        end
                    end
                end
                default: begin
                    st   <= AUTO;
                    tick <= reload;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_scroll_sequencer.sv
// tb_scroll_sequencer: scoreboard bench; stimulus queues expected pointer steps,
// memory writes and output probes, a negedge monitor pops and compares them.
module tb_scroll_sequencer;
    logic       clk_out = 1'b0;
    logic       reset_use = 1'b1;
    logic       mode_sw = 1'b1;
    logic       btn_next = 1'b0;
    logic       btn_prev = 1'b0;
    logic [1:0] speed_sel = 2'd0;
    logic       wr_valid = 1'b0;
    logic [3:0] wr_addr = 4'd0;
    logic [3:0] wr_data = 4'd0;
    logic       wr_ready, step, mem_we;
    logic [3:0] pointer, mem_waddr, mem_wdata;
    logic [1:0] state;

    typedef struct packed {
        logic [2:0] kind;
        logic [3:0] val;
    } probe_t;

    probe_t     probes[$];
    logic [3:0] exp_ptr[$];
    logic [7:0] exp_wr[$];
    int         checks = 0;
    int         errors = 0;
    bit         done = 1'b0;
    bit         fin = 1'b0;

    always #5 clk_out = ~clk_out;

    scroll_sequencer #(
        .PERIOD(8), .TICK_W(3), .DEB_CYCLES(4), .DEB_W(2)
    ) dut (
        .clk_out(clk_out), .reset_use(reset_use), .mode_sw(mode_sw),
        .btn_next(btn_next), .btn_prev(btn_prev), .speed_sel(speed_sel),
        .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_ready(wr_ready), .pointer(pointer), .step(step), .mem_we(mem_we),
        .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .state(state)
    );

    function automatic logic [3:0] observe(input logic [2:0] k);
        case (k)
            3'd0:    return pointer;
            3'd1:    return {2'b00, state};
            3'd2:    return {3'b000, wr_ready};
            3'd3:    return {3'b000, mem_we};
            default: return {3'b000, step};
        endcase
    endfunction

    function automatic string kname(input logic [2:0] k);
        case (k)
            3'd0:    return "pointer";
            3'd1:    return "state";
            3'd2:    return "wr_ready";
            3'd3:    return "mem_we";
            default: return "step";
        endcase
    endfunction

    always @(negedge clk_out) begin
        probe_t     pr;
        logic [3:0] e;
        logic [7:0] w;
        while (probes.size() > 0) begin
            pr = probes.pop_front();
            checks++;
            if (observe(pr.kind) !== pr.val) begin
                errors++;
                $display("FAIL %s: got %0d expected %0d at %0t", kname(pr.kind), observe(pr.kind), pr.val, $time);
            end
        end
        if (step) begin
            checks++;
            if (exp_ptr.size() == 0) begin
                errors++;
                $display("FAIL unexpected_step: pointer %0d, no step expected at %0t", pointer, $time);
            end else begin
                e = exp_ptr.pop_front();
                if (pointer !== e) begin
                    errors++;
                    $display("FAIL step_pointer: got %0d expected %0d at %0t", pointer, e, $time);
                end
            end
        end
        if (mem_we) begin
            checks++;
            if (exp_wr.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: addr %0h data %0h at %0t", mem_waddr, mem_wdata, $time);
            end else begin
                w = exp_wr.pop_front();
                if ({mem_waddr, mem_wdata} !== w) begin
                    errors++;
                    $display("FAIL mem_write: got %h/%h expected %h/%h at %0t", mem_waddr, mem_wdata, w[7:4], w[3:0], $time);
                end
            end
        end
        if (done && !fin) begin
            fin = 1'b1;
            checks++;
            if (exp_ptr.size() != 0 || exp_wr.size() != 0) begin
                errors++;
                $display("FAIL leftover: %0d steps and %0d writes never seen, expected 0", exp_ptr.size(), exp_wr.size());
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk_out);
        #1;
    endtask

    task automatic probe(input logic [2:0] k, input logic [3:0] v);
        probes.push_back('{kind: k, val: v});
    endtask

    task automatic press_btn(input logic n, input logic p);
        btn_next = n;
        btn_prev = p;
        cyc(8);
        btn_next = 1'b0;
        btn_prev = 1'b0;
        cyc(8);
    endtask

    // Holds one beat until the DUT accepts it; an expired bound becomes a failing wr_ready probe
    task automatic wr(input logic [3:0] a, input logic [3:0] d);
        bit ok = 1'b0;
        wr_addr  = a;
        wr_data  = d;
        wr_valid = 1'b1;
        exp_wr.push_back({a, d});
        for (int i = 0; i < 10 && !ok; i++) begin
            ok = wr_ready;
            cyc(1);
        end
        if (!ok) probe(3'd2, 4'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not end, expected finish");
        $fatal(1);
    end

    initial begin
        cyc(3);
        probe(3'd0, 4'd0);
        probe(3'd1, 4'd0);
        probe(3'd2, 4'd0);
        probe(3'd3, 4'd0);
        probe(3'd4, 4'd0);
        for (int i = 1; i <= 16; i++) exp_ptr.push_back(4'(i));
        cyc(1);
        reset_use = 1'b0;
        // auto rotation with period 8, full wrap at 128 cycles
        cyc(7);
        probe(3'd0, 4'd0);
        cyc(1);
        probe(3'd0, 4'd1);
        cyc(120);
        probe(3'd0, 4'd0);
        // faster periods take effect at the next reload
        speed_sel = 2'd2;
        for (int i = 1; i <= 4; i++) exp_ptr.push_back(4'(i));
        cyc(9);
        probe(3'd0, 4'd1);
        cyc(5);
        probe(3'd0, 4'd4);
        speed_sel = 2'd3;
        for (int i = 5; i <= 8; i++) exp_ptr.push_back(4'(i));
        cyc(1);
        probe(3'd0, 4'd4);
        cyc(4);
        probe(3'd0, 4'd8);
        // switch to manual: two more auto steps slip through the synchroniser
        mode_sw = 1'b0;
        exp_ptr.push_back(4'd9);
        exp_ptr.push_back(4'd10);
        cyc(5);
        probe(3'd1, 4'd1);
        probe(3'd0, 4'd10);
        speed_sel = 2'd0;
        exp_ptr.push_back(4'd11);
        btn_next = 1'b1;
        cyc(6);
        probe(3'd0, 4'd10);
        cyc(1);
        probe(3'd0, 4'd11);
        cyc(3);
        btn_next = 1'b0;
        cyc(10);
        // 3-cycle glitch is filtered
        btn_next = 1'b1;
        cyc(3);
        btn_next = 1'b0;
        cyc(10);
        probe(3'd0, 4'd11);
        for (int i = 12; i <= 16; i++) begin
            exp_ptr.push_back(4'(i));
            press_btn(1'b1, 1'b0);
        end
        probe(3'd0, 4'd0);
        exp_ptr.push_back(4'd15);
        press_btn(1'b0, 1'b1);
        probe(3'd0, 4'd15);
        press_btn(1'b1, 1'b1);
        probe(3'd0, 4'd15);
        for (int i = 16; i <= 21; i++) begin
            exp_ptr.push_back(4'(i));
            press_btn(1'b1, 1'b0);
        end
        probe(3'd0, 4'd5);
        probe(3'd1, 4'd1);
        // load three characters from manual at pointer 5
        exp_ptr.push_back(4'd0);
        wr(4'd3, 4'hA);
        probe(3'd1, 4'd2);
        probe(3'd2, 4'd1);
        wr(4'd4, 4'hB);
        wr(4'd5, 4'hC);
        wr_valid = 1'b0;
        cyc(1);
        probe(3'd1, 4'd1);
        probe(3'd0, 4'd0);
        probe(3'd2, 4'd0);
        probe(3'd3, 4'd0);
        // mode sync change and wr_valid on the same edge: load wins
        mode_sw = 1'b1;
        cyc(2);
        wr_valid = 1'b1;
        wr_addr  = 4'd6;
        wr_data  = 4'hD;
        cyc(1);
        probe(3'd1, 4'd2);
        wr(4'd6, 4'hD);
        wr_valid = 1'b0;
        cyc(1);
        probe(3'd1, 4'd0);
        probe(3'd0, 4'd0);
        exp_ptr.push_back(4'd1);
        cyc(8);
        probe(3'd0, 4'd1);
        // reset lands mid-load just after an accepted beat; that write is dropped
        wr_valid = 1'b1;
        wr_addr  = 4'd7;
        wr_data  = 4'hE;
        cyc(3);
        reset_use = 1'b1;
        #1;
        probe(3'd3, 4'd0);
        probe(3'd2, 4'd0);
        probe(3'd0, 4'd0);
        probe(3'd1, 4'd0);
        wr_valid = 1'b0;
        cyc(2);
        reset_use = 1'b0;
        wr(4'd8, 4'hF);
        wr_valid = 1'b0;
        cyc(1);
        probe(3'd1, 4'd0);
        probe(3'd0, 4'd0);
        cyc(2);
        done = 1'b1;
        cyc(3);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
